axis_random_throttle: RTL and testbench



---
 rtl/axis_random_throttle.sv | 105 ++++++++++
 tb/tb_axis_random_throttle.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_random_throttle.sv
// axis_random_throttle: AXI4-Stream pass-through stage that injects reproducible
// pseudo-random backpressure (in_tready low) and valid gaps (out_tvalid low).
// A 2-entry registered buffer decouples the two sides. A single 16-bit
// Fibonacci LFSR, reloaded from SEED on reset, drives both stall decisions,
// so the same seed and stimulus always give the same cycle-by-cycle trace.
module axis_random_throttle #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [7:0]  IN_STALL   = 8'd64,
  parameter logic [7:0]  OUT_GAP    = 8'd64
) (
  input  logic                  clk,
  input  logic                  resetn,
  // upstream (slave) side
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  in_tlast,
  // downstream (master) side
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast,
  // completed downstream handshakes, wraps silently
  output logic [31:0]           beat_count
);

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t       mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        holding;
  logic [15:0] lfsr;

  logic        lfsr_fb;
  logic [8:0]  in_diff;
  logic [8:0]  out_diff;
  logic        in_stall;
  logic        out_gap;
  logic        wr_en;
  logic        rd_en;

  // Feedback for x^16 + x^14 + x^13 + x^11, shifting toward bit 0.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // "byte < threshold" is the borrow of a 9-bit subtraction; a threshold of 0
  // can never borrow, so it never stalls.
  assign in_diff  = {1'b0, lfsr[7:0]}  - {1'b0, IN_STALL};
  assign out_diff = {1'b0, lfsr[15:8]} - {1'b0, OUT_GAP};
  assign in_stall = in_diff[8];
  assign out_gap  = out_diff[8];

  // Full blocks the producer even when a read happens in the same cycle.
  assign in_tready  = resetn && (count != 2'd2) && !in_stall;
  // A gap may only delay the start of a beat; once shown it is held.
  assign out_tvalid = (count != 2'd0) && (holding || !out_gap);
  assign out_tdata  = mem[rd_ptr].data;
  assign out_tlast  = mem[rd_ptr].last;

  assign wr_en = in_tvalid && in_tready;
  assign rd_en = out_tvalid && out_tready;

  // Control state: LFSR, pointers, occupancy, hold flag and beat counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr       <= SEED_EFF;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      holding    <= 1'b0;
      beat_count <= 32'd0;
    end else begin
      lfsr    <= {lfsr_fb, lfsr[15:1]};
      holding <= out_tvalid && !out_tready;
      if (wr_en) wr_ptr <= !wr_ptr;
      if (rd_en) begin
        rd_ptr     <= !rd_ptr;
        beat_count <= beat_count + 32'd1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Beat storage, written on an accepted upstream beat.
  // NOTE: the data array has no reset; its contents are only observed
  // through count, which is reset, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{last: in_tlast, data: in_tdata};
  end

endmodule

// File: tb/tb_axis_random_throttle.sv
// Self-checking bench for axis_random_throttle.
// dut   : default parameters, checked cycle-by-cycle against a queue model.
// dut_z : SEED=0, same stimulus, must match the same model (seed fallback).
// dut_f : no stalls/gaps, used for the vector table and the full-rate stream.
module tb_axis_random_throttle;

  localparam logic [15:0] DEF_SEED = 16'hACE1;
  localparam int          IN_STALL = 64;
  localparam int          OUT_GAP  = 64;

  logic        clk = 1'b0;
  logic        resetn;

  logic [31:0] in_tdata;
  logic        in_tvalid, in_tlast, out_tready;
  logic        in_tready, out_tvalid, out_tlast;
  logic [31:0] out_tdata, beat_count;

  logic        z_in_tready, z_out_tvalid, z_out_tlast;
  logic [31:0] z_out_tdata, z_beat_count;

  logic [31:0] f_in_tdata;
  logic        f_in_tvalid, f_in_tlast, f_out_tready;
  logic        f_in_tready, f_out_tvalid, f_out_tlast;
  logic [31:0] f_out_tdata, f_beat_count;

  always #5 clk = ~clk;

  axis_random_throttle #(.DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .beat_count(beat_count)
  );

  axis_random_throttle #(.DATA_WIDTH(32), .SEED(16'h0000)) dut_z (
    .clk(clk), .resetn(resetn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(z_in_tready), .in_tlast(in_tlast),
    .out_tdata(z_out_tdata), .out_tvalid(z_out_tvalid), .out_tready(out_tready), .out_tlast(z_out_tlast),
    .beat_count(z_beat_count)
  );

  axis_random_throttle #(.DATA_WIDTH(32), .IN_STALL(8'd0), .OUT_GAP(8'd0)) dut_f (
    .clk(clk), .resetn(resetn),
    .in_tdata(f_in_tdata), .in_tvalid(f_in_tvalid), .in_tready(f_in_tready), .in_tlast(f_in_tlast),
    .out_tdata(f_out_tdata), .out_tvalid(f_out_tvalid), .out_tready(f_out_tready), .out_tlast(f_out_tlast),
    .beat_count(f_beat_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  // ---------------- behavioural model of the default-parameter block -------
  logic [32:0] q [$];
  logic [15:0] m_lfsr;
  logic        m_hold;
  logic [31:0] m_beats;
  logic        prev_stall;
  logic [32:0] prev_beat;
  logic        in_hs, out_hs;
  logic [32:0] hs_beat;
  int          stall_seen, gap_seen;
  logic        exp_trace [100];
  int          fk;

  task automatic model_reset();
    q.delete();
    m_lfsr     = DEF_SEED;
    m_hold     = 1'b0;
    m_beats    = 32'd0;
    prev_stall = 1'b0;
  endtask

  // One clock of the main pair: drive at the falling edge, compare, advance.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic l, input logic ordy);
    logic        m_rdy, m_vld;
    logic [32:0] head;
    in_tvalid = iv; in_tdata = d; in_tlast = l; out_tready = ordy;
    #1;
    m_rdy = (q.size() < 2) && (int'(m_lfsr[7:0]) >= IN_STALL);
    m_vld = (q.size() > 0) && (m_hold || (int'(m_lfsr[15:8]) >= OUT_GAP));
    head  = (q.size() > 0) ? q[0] : 33'd0;
    check("in_tready", in_tready, m_rdy);
    check("seed0_in_tready", z_in_tready, m_rdy);
    check("out_tvalid", out_tvalid, m_vld);
    check("seed0_out_tvalid", z_out_tvalid, m_vld);
    if (m_vld) begin
      check("out_beat", {out_tlast, out_tdata}, head);
      check("seed0_out_beat", {z_out_tlast, z_out_tdata}, head);
    end
    check("beat_count", beat_count, m_beats);
    check("seed0_beat_count", z_beat_count, m_beats);
    if (prev_stall) begin
      check("axis_hold_valid", out_tvalid, 1'b1);
      check("axis_hold_beat", {out_tlast, out_tdata}, prev_beat);
    end
    prev_stall = out_tvalid && !ordy;
    prev_beat  = {out_tlast, out_tdata};
    if (!in_tready) stall_seen++;
    if ((q.size() > 0) && !out_tvalid) gap_seen++;
    in_hs   = iv && m_rdy;
    out_hs  = m_vld && ordy;
    hs_beat = {out_tlast, out_tdata};
    if (out_hs) begin
      void'(q.pop_front());
      m_beats = m_beats + 32'd1;
    end
    if (in_hs) q.push_back({l, d});
    m_hold = m_vld && !ordy;
    m_lfsr = lfsr_next(m_lfsr);
    @(posedge clk); @(negedge clk);
  endtask

  // Fast-instance drive; the idle main pair's in_tready is checked against
  // the seed trace for the first 100 cycles after the initial reset.
  task automatic f_apply(input logic iv, input logic [31:0] d, input logic l, input logic ordy);
    f_in_tvalid = iv; f_in_tdata = d; f_in_tlast = l; f_out_tready = ordy;
    #1;
    if (fk < 100) begin
      check("first_run_trace", in_tready, exp_trace[fk]);
      check("seed0_first_run_trace", z_in_tready, exp_trace[fk]);
    end
  endtask

  task automatic tick();
    @(posedge clk); @(negedge clk);
    fk++;
  endtask

  task automatic do_reset();
    in_tvalid = 1'b0; out_tready = 1'b0;
    resetn = 1'b0;
    #1;
    model_reset();
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct packed {
    logic        iv;
    logic [31:0] d;
    logic        l;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic        e_last;
    logic [31:0] e_beats;
  } vec_t;

  vec_t vt [7];

  initial begin
    int s, g, got;
    logic pend;
    logic [15:0] l;
    logic iv;

    // Short fixed sequence on the no-stall instance: fill, full, read-while-full,
    // simultaneous read/write, drain.
    vt[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'd0};
    vt[1] = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 32'd0};
    vt[2] = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 32'd0};
    vt[3] = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 32'd0};
    vt[4] = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 1'b1, 32'd1};
    vt[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 32'd2};
    vt[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'd3};

    l = DEF_SEED;
    for (int k = 0; k < 100; k++) begin
      exp_trace[k] = (int'(l[7:0]) >= IN_STALL);
      l = lfsr_next(l);
    end

    resetn = 1'b0;
    in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0; out_tready = 1'b0;
    f_in_tvalid = 1'b0; f_in_tdata = '0; f_in_tlast = 1'b0; f_out_tready = 1'b0;
    model_reset();
    stall_seen = 0; gap_seen = 0; fk = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_in_tready", in_tready, 1'b0);
    check("rst_out_tvalid", out_tvalid, 1'b0);
    check("rst_beat_count", beat_count, 32'd0);
    check("rst_lfsr", dut.lfsr, DEF_SEED);
    check("rst_seed0_lfsr", dut_z.lfsr, DEF_SEED);
    check("rst_f_in_tready", f_in_tready, 1'b0);
    resetn = 1'b1;

    // Vector table
    for (int i = 0; i < 7; i++) begin
      f_apply(vt[i].iv, vt[i].d, vt[i].l, vt[i].ordy);
      check("vec_in_tready", f_in_tready, vt[i].e_rdy);
      check("vec_out_tvalid", f_out_tvalid, vt[i].e_vld);
      if (vt[i].e_vld) begin
        check("vec_out_tdata", f_out_tdata, vt[i].e_data);
        check("vec_out_tlast", f_out_tlast, vt[i].e_last);
      end
      check("vec_beat_count", f_beat_count, vt[i].e_beats);
      tick();
    end

    // Full-rate stream of 1024 beats, one per cycle after a 1-cycle fill
    for (int c = 0; c <= 1024; c++) begin
      f_apply(c < 1024, 32'(c), (c % 256) == 255, 1'b1);
      check("fast_in_tready", f_in_tready, 1'b1);
      check("fast_out_tvalid", f_out_tvalid, c >= 1);
      if (c >= 1) begin
        check("fast_out_tdata", f_out_tdata, 32'(c - 1));
        check("fast_out_tlast", f_out_tlast, ((c - 1) % 256) == 255);
      end
      tick();
    end
    f_apply(1'b0, 32'h0, 1'b0, 1'b1);
    check("fast_beat_count", f_beat_count, 32'd1027);
    check("fast_idle", f_out_tvalid, 1'b0);

    // Random upstream, always-ready downstream, 4096 beats
    do_reset();
    s = 0; pend = 1'b0; g = 0;
    while ((s < 4096 || q.size() > 0) && g < 30000) begin
      iv = (s < 4096) && (pend || ($urandom_range(3) != 0));
      cycle(iv, 32'(s), (s % 256) == 255, 1'b1);
      if (in_hs) s++;
      pend = iv && !in_hs;
      g++;
    end
    check("stream_all_sent", s, 4096);
    check("stream_drained", q.size(), 0);
    check("stream_beat_count", beat_count, 32'd4096);
    check("stall_observed", stall_seen > 0, 1'b1);
    check("gap_observed", gap_seen > 0, 1'b1);

    // Backpressure hold: two beats loaded, downstream stalled 20 cycles
    g = 0;
    do begin cycle(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0); g++; end while (!in_hs && g < 100);
    check("load_a5_bound", in_hs, 1'b1);
    g = 0;
    do begin cycle(1'b1, 32'h5A5A5A5A, 1'b1, 1'b0); g++; end while (!in_hs && g < 100);
    check("load_5a_bound", in_hs, 1'b1);
    g = 0;
    while (!out_tvalid && g < 100) begin cycle(1'b0, 32'h0, 1'b0, 1'b0); g++; end
    check("hold_valid_start", out_tvalid, 1'b1);
    for (int k = 0; k < 20; k++) begin
      check("hold_in_tready", in_tready, 1'b0);
      check("hold_out_tvalid", out_tvalid, 1'b1);
      check("hold_out_tdata", out_tdata, 32'hA5A5A5A5);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
    end
    got = 0; g = 0;
    while (got < 2 && g < 100) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (out_hs) begin
        if (got == 0) check("drain_first", hs_beat, {1'b0, 32'hA5A5A5A5});
        else          check("drain_second", hs_beat, {1'b1, 32'h5A5A5A5A});
        got++;
      end
      g++;
    end
    check("drain_count", got, 2);

    // Random downstream ready: protocol hold is checked every cycle
    s = 0; pend = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      iv = pend || ($urandom_range(1) == 1);
      cycle(iv, 32'h1000_0000 + 32'(s), s[0] ^ s[3], $urandom_range(1) == 1);
      if (in_hs) s++;
      pend = iv && !in_hs;
    end
    g = 0;
    while (q.size() > 0 && g < 200) begin cycle(1'b0, 32'h0, 1'b0, 1'b1); g++; end
    check("random_ready_drained", q.size(), 0);

    // Mid-stream reset with two beats buffered
    s = 0; g = 0;
    while (q.size() < 2 && g < 200) begin
      cycle(1'b1, 32'hC000_0000 + 32'(s), 1'b0, 1'b0);
      if (in_hs) s++;
      g++;
    end
    check("prefill_two", q.size(), 2);
    in_tvalid = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_out_tvalid", out_tvalid, 1'b0);
    check("midrst_beat_count", beat_count, 32'd0);
    check("midrst_in_tready", in_tready, 1'b0);
    check("midrst_lfsr", dut.lfsr, DEF_SEED);
    check("midrst_seed0_lfsr", dut_z.lfsr, DEF_SEED);
    model_reset();
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      check("rerun_trace", in_tready, exp_trace[k]);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
    end

    // beat_count wrap from all-ones
    force dut.beat_count = 32'hFFFF_FFFF;
    force dut_z.beat_count = 32'hFFFF_FFFF;
    m_beats = 32'hFFFF_FFFF;
    #1;
    release dut.beat_count;
    release dut_z.beat_count;
    g = 0;
    do begin cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b1); g++; end while (!in_hs && g < 100);
    check("wrap_load", in_hs, 1'b1);
    g = 0;
    while (!out_hs && g < 100) begin cycle(1'b0, 32'h0, 1'b0, 1'b1); g++; end
    check("wrap_handshake", out_hs, 1'b1);
    check("wrap_beat_data", hs_beat, {1'b1, 32'hDEADBEEF});
    check("beat_count_wrap", beat_count, 32'd0);
    check("seed0_beat_count_wrap", z_beat_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
